// File: rtl/spike_packet_buffer.sv
// Show-ahead spike packet FIFO with timestep FSM (IDLE/ACTIVE/DRAIN) and almost-full flag.
// Optional statistics counters enabled by defining SPIKE_PACKET_BUFFER_STATS_EN.
module spike_packet_buffer #(
  parameter int DEPTH       = 8,
  parameter int FULL_MARGIN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [29:0] packet_in,
  input  logic        spike_out_valid,
  input  logic        grid_done,
  output logic        local_buffers_full,
  output logic [29:0] pkt_out,
  output logic        pkt_out_valid,
  input  logic        pkt_out_ready,
  output logic        drained,
  output logic        overflow,
  output logic [1:0]  buf_state
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
  ,
  output logic [15:0] dropped_count,
  output logic [15:0] sent_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX     = (AW+1)'(DEPTH);
  localparam logic [AW:0] FULL_THRESH = (AW+1)'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  logic [29:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_overflow;
  logic          r_drained;
  state_t        r_state;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_count_next;

  assign w_pop  = (r_count != '0) && pkt_out_ready;
  // A full FIFO still accepts a packet when the head leaves in the same cycle.
  assign w_push = spike_out_valid && ((r_count != CNT_MAX) || w_pop);
  assign w_drop = spike_out_valid && !w_push;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + (AW+1)'(1);
    else if (w_pop && !w_push)
      w_count_next = r_count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= packet_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_drained  <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= w_count_next;
      r_full    <= (w_count_next >= FULL_THRESH);
      r_drained <= 1'b0;
      if (w_drop)
        r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (tick)
            r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (tick)
            r_overflow <= 1'b1;
          if (grid_done)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (tick)
            r_overflow <= 1'b1;
          if (w_count_next == '0) begin
            r_state   <= S_IDLE;
            r_drained <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPIKE_PACKET_BUFFER_STATS_EN
  logic [15:0] r_dropped_count;
  logic [15:0] r_sent_count;

  always_ff @(posedge clk) begin
    if (!reset_n || (tick && r_state == S_IDLE)) begin
      r_dropped_count <= '0;
      r_sent_count    <= '0;
    end else begin
      if (w_drop && r_dropped_count != 16'hFFFF)
        r_dropped_count <= r_dropped_count + 16'd1;
      if (w_pop)
        r_sent_count <= r_sent_count + 16'd1;
    end
  end

  assign dropped_count = r_dropped_count;
  assign sent_count    = r_sent_count;
`endif

  // RAM is not reset, so the head is masked to zero while empty.
  assign pkt_out            = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign pkt_out_valid      = (r_count != '0);
  assign local_buffers_full = r_full;
  assign drained            = r_drained;
  assign overflow           = r_overflow;
  assign buf_state          = r_state;

endmodule

// File: tb/tb_spike_packet_buffer.sv
// Directed bench for spike_packet_buffer with a packet scoreboard and FSM/flag reference model.
module tb_spike_packet_buffer;
  localparam int DEPTH = 8;
  localparam int FM    = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [29:0] packet_in;
  logic        spike_out_valid;
  logic        grid_done;
  logic        local_buffers_full;
  logic [29:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic        drained;
  logic        overflow;
  logic [1:0]  buf_state;
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
  logic [15:0] dropped_count;
  logic [15:0] sent_count;
`endif

  spike_packet_buffer #(.DEPTH(DEPTH), .FULL_MARGIN(FM)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick),
    .packet_in(packet_in),
    .spike_out_valid(spike_out_valid),
    .grid_done(grid_done),
    .local_buffers_full(local_buffers_full),
    .pkt_out(pkt_out),
    .pkt_out_valid(pkt_out_valid),
    .pkt_out_ready(pkt_out_ready),
    .drained(drained),
    .overflow(overflow),
    .buf_state(buf_state)
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
    ,
    .dropped_count(dropped_count),
    .sent_count(sent_count)
`endif
  );

  always #5 clk = ~clk;

  logic [29:0] q[$];
  int m_state;
  bit m_ovf;
  int m_drop;
  int m_sent;
  int vectors;
  int miscompares;
  int drained_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the model before the edge, compare flags after it.
  task automatic cycle();
    bit pop;
    bit push;
    bit exp_drained;
    pop = 0;
    push = 0;
    exp_drained = 0;
    if (reset_n) begin
      chk("pkt_out_valid", pkt_out_valid, q.size() != 0);
      if (q.size() != 0) chk("pkt_out_head", pkt_out, q[0]);
      else chk("pkt_out_empty", pkt_out, 0);
      pop  = (q.size() != 0) && pkt_out_ready;
      push = spike_out_valid && (q.size() < DEPTH || pop);
      if (tick && m_state == 0) begin
        m_drop = 0;
        m_sent = 0;
      end else begin
        if (spike_out_valid && !push && m_drop < 65535) m_drop++;
        if (pop) m_sent = (m_sent + 1) % 65536;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(packet_in);
      if (spike_out_valid && !push) m_ovf = 1;
      case (m_state)
        0: if (tick) m_state = 1;
        1: begin
          if (tick) m_ovf = 1;
          if (grid_done) m_state = 2;
        end
        default: begin
          if (tick) m_ovf = 1;
          if (q.size() == 0) begin
            m_state = 0;
            exp_drained = 1;
          end
        end
      endcase
    end else begin
      q.delete();
      m_state = 0;
      m_ovf = 0;
      m_drop = 0;
      m_sent = 0;
    end
    @(posedge clk);
    #1;
    if (drained === 1'b1) drained_seen++;
    chk("local_buffers_full", local_buffers_full, (DEPTH - q.size()) <= FM);
    chk("overflow", overflow, m_ovf);
    chk("buf_state", buf_state, m_state);
    chk("drained", drained, exp_drained);
`ifdef SPIKE_PACKET_BUFFER_STATS_EN
    chk("dropped_count", dropped_count, m_drop);
    chk("sent_count", sent_count, m_sent);
`endif
    $display("t=%0t rst_n=%0b tick=%0b vin=%0b pin=%08h gd=%0b rdy=%0b | vout=%0b pout=%08h full=%0b ovf=%0b st=%0d drn=%0b",
             $time, reset_n, tick, spike_out_valid, packet_in, grid_done, pkt_out_ready,
             pkt_out_valid, pkt_out, local_buffers_full, overflow, buf_state, drained);
  endtask

  task automatic push_pkt(input logic [29:0] p);
    spike_out_valid = 1'b1;
    packet_in = p;
    cycle();
    spike_out_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    drained_seen = 0;
    m_state = 0;
    m_ovf = 0;
    m_drop = 0;
    m_sent = 0;
    reset_n = 1'b0;
    tick = 1'b0;
    packet_in = '0;
    spike_out_valid = 1'b0;
    grid_done = 1'b0;
    pkt_out_ready = 1'b0;

    // Reset state
    cycle();
    do_reset();
    chk("rst_valid", pkt_out_valid, 0);
    chk("rst_pkt_out", pkt_out, 0);
    chk("rst_full", local_buffers_full, 0);

    // Three pushes held, then released in order
    push_pkt(30'h0ABC_0001);
    push_pkt(30'h1234_5678);
    push_pkt(30'h3FFF_FFFF);
    chk("hold_head", pkt_out, 30'h0ABC_0001);
    chk("hold_full", local_buffers_full, 0);
    pkt_out_ready = 1'b1;
    repeat (3) cycle();
    chk("emptied", pkt_out_valid, 0);
    pkt_out_ready = 1'b0;

    // Fill to DEPTH, simultaneous push/pop at full, then a dropped packet
    do_reset();
    for (int i = 0; i < 7; i++) push_pkt(30'($urandom));
    chk("almost_full_at7", local_buffers_full, 1);
    push_pkt(30'($urandom));
    chk("no_ovf_at8", overflow, 0);
    pkt_out_ready = 1'b1;
    push_pkt(30'($urandom));
    pkt_out_ready = 1'b0;
    chk("full_pushpop_ovf", overflow, 0);
    chk("full_pushpop_full", local_buffers_full, 1);
    push_pkt(30'h2222_2222);
    chk("drop_ovf", overflow, 1);
    pkt_out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    pkt_out_ready = 1'b0;

    // Timestep flow: tick, two packets, grid_done, drain
    do_reset();
    tick = 1'b1; cycle(); tick = 1'b0;
    chk("state_active", buf_state, 1);
    push_pkt(30'h0000_0011);
    push_pkt(30'h0000_0022);
    grid_done = 1'b1; cycle(); grid_done = 1'b0;
    chk("state_drain", buf_state, 2);
    drained_seen = 0;
    pkt_out_ready = 1'b1;
    cycle();
    chk("drain_mid_state", buf_state, 2);
    cycle();
    chk("drained_pulse", drained, 1);
    chk("state_idle", buf_state, 0);
    cycle();
    chk("drained_once", drained_seen, 1);
    pkt_out_ready = 1'b0;

    // grid_done with empty FIFO, then tick while ACTIVE
    tick = 1'b1; cycle(); tick = 1'b0;
    grid_done = 1'b1; cycle(); grid_done = 1'b0;
    chk("empty_drain_state", buf_state, 2);
    cycle();
    chk("empty_drain_pulse", drained, 1);
    tick = 1'b1; cycle(); cycle(); tick = 1'b0;
    chk("tick_active_ovf", overflow, 1);

    // Pointer wrap with 20 push/pop pairs
    do_reset();
    pkt_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_pkt(30'(i * 30'h0101_0101 + 7));
    cycle();
    chk("wrap_no_ovf", overflow, 0);
    chk("wrap_left", q.size(), 0);
    pkt_out_ready = 1'b0;

    // Reset while draining five packets
    do_reset();
    tick = 1'b1; cycle(); tick = 1'b0;
    for (int i = 0; i < 5; i++) push_pkt(30'($urandom));
    grid_done = 1'b1; cycle(); grid_done = 1'b0;
    chk("pre_rst_drain", buf_state, 2);
    do_reset();
    chk("rst_drain_valid", pkt_out_valid, 0);
    chk("rst_drain_state", buf_state, 0);
    chk("rst_drain_drained", drained, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spike_packet_buffer.md
SPIKE_PACKET_BUFFER -- requirements
Module: spike_packet_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 4..64).
REQ-002 Parameter FULL_MARGIN, default 1, free entries at or below which local_buffers_full asserts.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 tick  input  1  one-cycle pulse marking start of a timestep.
REQ-006 packet_in  input  30  spike packet from the neuron grid: [29:21] dx, [20:12] dy, [11:4] axon, [3:0] delivery tick.
REQ-007 spike_out_valid  input  1  packet_in is valid this cycle (single-cycle strobe, no backpressure).
REQ-008 grid_done  input  1  one-cycle pulse: the neuron grid has finished the timestep.
REQ-009 local_buffers_full  output  1  almost-full flag back to the grid controller.
REQ-010 pkt_out  output  30  head-of-FIFO packet to the router.
REQ-011 pkt_out_valid  output  1  pkt_out holds a valid packet.
REQ-012 pkt_out_ready  input  1  router accepts pkt_out this cycle.
REQ-013 drained  output  1  one-cycle pulse: timestep output fully handed to the router.
REQ-014 overflow  output  1  sticky: a packet was dropped.
REQ-015 buf_state  output  2  current FSM state encoding.

Function
REQ-016 Push occurs when spike_out_valid=1 and (count<DEPTH or a pop occurs in the same cycle).
REQ-017 Pop occurs when pkt_out_valid=1 and pkt_out_ready=1.
REQ-018 Push and pop in the same cycle leave count unchanged; at count=DEPTH the simultaneous push is accepted.
REQ-019 spike_out_valid=1 at count=DEPTH with no pop drops the packet and sets overflow; count and contents remain unchanged.
REQ-020 FIFO is show-ahead: pkt_out=head entry; pkt_out_valid=(count!=0); a packet pushed at edge N is first visible after edge N.
REQ-021 pkt_out_valid, once asserted, and pkt_out stay stable until pop.
REQ-022 local_buffers_full=(DEPTH-count)<=FULL_MARGIN, registered from post-update count.
REQ-023 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-024 FSM states: IDLE=0, ACTIVE=1, DRAIN=2.
REQ-025 IDLE->ACTIVE on tick; ACTIVE->DRAIN on grid_done; DRAIN->IDLE when post-update count=0, pulsing drained with that transition.
REQ-026 grid_done in IDLE or DRAIN is ignored; tick in ACTIVE or DRAIN is ignored and sets overflow.
REQ-027 Pushes and pops are honoured in every state, including IDLE.
REQ-028 grid_done in ACTIVE with count=0 and no push enters DRAIN, then IDLE with drained pulse the next cycle.

Reset
REQ-029 reset_n=0 at a rising edge clears pointers, count, overflow, and drained, and sets state to IDLE.
REQ-030 Reset mid-operation discards all buffered packets; FIFO RAM contents need no reset.
REQ-031 After reset: local_buffers_full=0, pkt_out_valid=0, drained=0, overflow=0, buf_state=0, pkt_out=0.

Configuration
REQ-032 Macro SPIKE_PACKET_BUFFER_STATS_EN, when defined, adds output dropped_count (16 bits, saturating, +1 per dropped packet) and output sent_count (16 bits, wrapping, +1 per pop); both are cleared by reset and by tick in IDLE.
REQ-033 Without SPIKE_PACKET_BUFFER_STATS_EN, both ports and their counters are absent; all other behaviour is identical.

Verification
REQ-034 Reset, then 3 pushes with pkt_out_ready=0: count=3, pkt_out=first packet, local_buffers_full=0; raise ready: packets leave in order over 3 cycles.
REQ-035 DEPTH=8, FULL_MARGIN=1, ready=0, 7 pushes: local_buffers_full=1 after the 7th; 8th push accepted; 9th push dropped, overflow=1.
REQ-036 Count=8 with simultaneous push and pop: push accepted, count stays 8, overflow stays 0.
REQ-037 tick, 2 pushes, grid_done, ready=1: state 0->1->2, then drained pulses exactly once when the 2nd packet pops, state=0.
REQ-038 Pointer wrap: 20 push/pop pairs at DEPTH=8: output order matches input order, no drops.
REQ-039 reset_n=0 with count=5 in DRAIN: next cycle count=0, pkt_out_valid=0, state=IDLE, no drained pulse.
